dds_cmd_sequencer: RTL and testbench

- Command scheduler in front of the DDS serial register-write engine.
- Arbitrates between two command sources and presents one valid/ready command stream to the engine:
  - one-shot manual commands from the VIO (RW flag, 32-bit data, start level);
  - an autonomous sequence that replays a loadable table of 32-bit register words with a programmable dwell between writes.
- Sits between the VIO/control logic and the serial engine inside the DDS top level.

---
 rtl/dds_cmd_sequencer_if.sv | 27 ++
 rtl/dds_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dds_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_cmd_sequencer_if.sv
// rtl/dds_cmd_sequencer_if.sv - command stream between the sequencer and the DDS serial write engine
//
// Ports (signals):
//   cmd_valid - command valid (sequencer -> engine)
//   cmd_rw    - command RW flag
//   cmd_data  - 32-bit command word
//   cmd_ready - engine accepts the command (engine -> sequencer)
interface dds_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_rw;
  logic [31:0] cmd_data;
  logic        cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_rw,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rw,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/dds_cmd_sequencer.sv
// rtl/dds_cmd_sequencer.sv - schedules manual and table-driven register writes to the DDS serial engine
//
// Ports:
//   sys_clk, rstn_i           - clock, asynchronous active-low reset
//   man_start/man_rw/man_data - manual command request (rising edge) with its RW flag and data
//   run_seq                   - sequence enable level
//   tbl_wr_en/addr/data       - table write port
//   seq_last                  - index of last active table entry
//   dwell                     - idle cycles after each sequence write
//   cmd                       - command stream to the serial engine (master side)
//   busy, seq_idx             - state != IDLE, current table index
//   seq_wrap, man_drop        - one-cycle pulses: index wrapped / manual edge discarded
module dds_cmd_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 32
) (
  input  logic                sys_clk,
  input  logic                rstn_i,
  input  logic                man_start,
  input  logic                man_rw,
  input  logic [31:0]         man_data,
  input  logic                run_seq,
  input  logic                tbl_wr_en,
  input  logic [ADDR_W-1:0]   tbl_wr_addr,
  input  logic [31:0]         tbl_wr_data,
  input  logic [ADDR_W-1:0]   seq_last,
  input  logic [DWELL_W-1:0]  dwell,
  dds_cmd_sequencer_if.master cmd,
  output logic                busy,
  output logic [ADDR_W-1:0]   seq_idx,
  output logic                seq_wrap,
  output logic                man_drop
);

  typedef enum logic [1:0] {IDLE, MAN_ISSUE, SEQ_ISSUE, SEQ_DWELL} state_t;

  state_t              state, state_nx;
  logic [31:0]         tbl [2**ADDR_W];
  logic                start_q;
  logic                man_pend, man_pend_nx;
  logic                man_rw_q, man_rw_nx;
  logic [31:0]         man_data_q, man_data_nx;
  logic                seq_act, seq_act_nx;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_cnt_nx;
  logic [ADDR_W-1:0]   seq_idx_nx;
  logic                seq_wrap_nx, man_drop_nx;
  logic                valid_nx, rw_nx;
  logic [31:0]         data_nx;

  logic xfer, man_edge, dwell_done, idx_wrap, advance;

  assign xfer       = cmd.cmd_valid & cmd.cmd_ready;
  assign man_edge   = man_start & ~start_q;
  assign dwell_done = (dwell_cnt == '0);
  // The index wraps either at the programmed last entry or, if seq_last was
  // lowered below the current index, at the natural end of the counter.
  assign idx_wrap   = (seq_idx == seq_last) || (seq_idx == '1);
  assign advance    = (state == SEQ_DWELL) && run_seq && dwell_done;
  assign busy       = (state != IDLE);

  // Table has no reset; a read in the same cycle as a write sees the old word.
  always_ff @(posedge sys_clk) begin
    if (tbl_wr_en) tbl[tbl_wr_addr] <= tbl_wr_data;
  end

  // State register and all registered outputs.
  always_ff @(posedge sys_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      man_pend      <= 1'b0;
      man_rw_q      <= 1'b0;
      man_data_q    <= '0;
      seq_act       <= 1'b0;
      dwell_cnt     <= '0;
      seq_idx       <= '0;
      seq_wrap      <= 1'b0;
      man_drop      <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_rw    <= 1'b0;
      cmd.cmd_data  <= '0;
    end else begin
      state         <= state_nx;
      start_q       <= man_start;
      man_pend      <= man_pend_nx;
      man_rw_q      <= man_rw_nx;
      man_data_q    <= man_data_nx;
      seq_act       <= seq_act_nx;
      dwell_cnt     <= dwell_cnt_nx;
      seq_idx       <= seq_idx_nx;
      seq_wrap      <= seq_wrap_nx;
      man_drop      <= man_drop_nx;
      cmd.cmd_valid <= valid_nx;
      cmd.cmd_rw    <= rw_nx;
      cmd.cmd_data  <= data_nx;
    end
  end

  // Next-state logic. Issue states only leave on a transfer, so a raised
  // cmd_valid is never withdrawn.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (man_pend)     state_nx = MAN_ISSUE;
        else if (run_seq) state_nx = SEQ_ISSUE;
      end
      MAN_ISSUE: begin
        if (xfer) state_nx = (run_seq && seq_act) ? SEQ_ISSUE : IDLE;
      end
      SEQ_ISSUE: begin
        if (xfer) state_nx = run_seq ? SEQ_DWELL : IDLE;
      end
      SEQ_DWELL: begin
        if (!run_seq)        state_nx = IDLE;
        else if (dwell_done) state_nx = man_pend ? MAN_ISSUE : SEQ_ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    valid_nx     = cmd.cmd_valid;
    rw_nx        = cmd.cmd_rw;
    data_nx      = cmd.cmd_data;
    man_pend_nx  = man_pend;
    man_rw_nx    = man_rw_q;
    man_data_nx  = man_data_q;
    man_drop_nx  = man_edge && man_pend;
    seq_act_nx   = seq_act;
    dwell_cnt_nx = dwell_cnt;
    seq_idx_nx   = seq_idx;
    seq_wrap_nx  = 1'b0;

    // cmd_valid rises one cycle after entering an issue state and drops on
    // the transfer edge, which guarantees an idle cycle between commands even
    // when MAN_ISSUE hands straight over to SEQ_ISSUE.
    if (xfer) begin
      valid_nx = 1'b0;
    end else if (!cmd.cmd_valid && state == MAN_ISSUE) begin
      valid_nx = 1'b1;
      rw_nx    = man_rw_q;
      data_nx  = man_data_q;
    end else if (!cmd.cmd_valid && state == SEQ_ISSUE) begin
      valid_nx = 1'b1;
      rw_nx    = 1'b0;
      data_nx  = tbl[seq_idx];
    end

    if (state == MAN_ISSUE && xfer) man_pend_nx = 1'b0;
    // An edge while a command is still pending is discarded; the latched
    // command stays untouched.
    if (man_edge && !man_pend) begin
      man_pend_nx = 1'b1;
      man_rw_nx   = man_rw;
      man_data_nx = man_data;
    end

    // seq_act remembers across MAN_ISSUE whether a sequence was interrupted.
    if (state_nx == IDLE)                                    seq_act_nx = 1'b0;
    else if (state_nx == SEQ_ISSUE || state_nx == SEQ_DWELL) seq_act_nx = 1'b1;

    if (state == SEQ_ISSUE && xfer)             dwell_cnt_nx = dwell;
    else if (state == SEQ_DWELL && !dwell_done) dwell_cnt_nx = dwell_cnt - 1'b1;

    if (state == IDLE && state_nx == SEQ_ISSUE) begin
      seq_idx_nx = '0;
    end else if (advance) begin
      seq_idx_nx  = idx_wrap ? '0 : seq_idx + 1'b1;
      seq_wrap_nx = idx_wrap;
    end
  end

endmodule

// File: tb/tb_dds_cmd_sequencer.sv
// tb/tb_dds_cmd_sequencer.sv - scoreboard bench for dds_cmd_sequencer
module tb_dds_cmd_sequencer;
  localparam int ADDR_W  = 3;
  localparam int DWELL_W = 32;

  logic                sys_clk = 1'b0;
  logic                rstn_i = 1'b0;
  logic                man_start = 1'b0;
  logic                man_rw = 1'b0;
  logic [31:0]         man_data = '0;
  logic                run_seq = 1'b0;
  logic                tbl_wr_en = 1'b0;
  logic [ADDR_W-1:0]   tbl_wr_addr = '0;
  logic [31:0]         tbl_wr_data = '0;
  logic [ADDR_W-1:0]   seq_last = '0;
  logic [DWELL_W-1:0]  dwell = '0;
  logic                busy;
  logic [ADDR_W-1:0]   seq_idx;
  logic                seq_wrap;
  logic                man_drop;

  dds_cmd_sequencer_if cmd_bus ();

  dds_cmd_sequencer #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
    .sys_clk     (sys_clk),
    .rstn_i      (rstn_i),
    .man_start   (man_start),
    .man_rw      (man_rw),
    .man_data    (man_data),
    .run_seq     (run_seq),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .seq_last    (seq_last),
    .dwell       (dwell),
    .cmd         (cmd_bus),
    .busy        (busy),
    .seq_idx     (seq_idx),
    .seq_wrap    (seq_wrap),
    .man_drop    (man_drop)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] sb_q[$];
  int          xcyc[$];
  int          wrap_cnt = 0;
  int          drop_cnt = 0;
  int          rise_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: stability while waiting, idle after transfer, scoreboard pop.
  initial begin
    logic        prev_v, prev_rw, prev_x, x;
    logic [31:0] prev_d;
    logic [32:0] e;
    prev_v = 1'b0; prev_rw = 1'b0; prev_x = 1'b0; prev_d = '0;
    forever begin
      @(negedge sys_clk);
      if (!rstn_i) begin
        prev_v = 1'b0;
        prev_x = 1'b0;
      end else begin
        if (prev_x) begin
          check_eq("idle_after_xfer", cmd_bus.cmd_valid, 0);
        end else if (prev_v) begin
          check_eq("hold_valid", cmd_bus.cmd_valid, 1);
          check_eq("hold_cmd", {cmd_bus.cmd_rw, cmd_bus.cmd_data}, {prev_rw, prev_d});
        end
        if (cmd_bus.cmd_valid && !prev_v) rise_cyc = cyc;
        if (seq_wrap) wrap_cnt++;
        if (man_drop) drop_cnt++;
        x = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
        if (x) begin
          xcyc.push_back(cyc);
          check_eq("sb_nonempty", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("xfer", {cmd_bus.cmd_rw, cmd_bus.cmd_data}, e);
          end
        end
        prev_v  = cmd_bus.cmd_valid;
        prev_rw = cmd_bus.cmd_rw;
        prev_d  = cmd_bus.cmd_data;
        prev_x  = x;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int b = 0;
    while (sb_q.size() != 0 && b < budget) begin
      @(negedge sys_clk);
      #1;
      b++;
    end
    check_eq(tag, sb_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int b = 0;
    while (cmd_bus.cmd_valid !== 1'b1 && b < budget) begin
      @(negedge sys_clk);
      #1;
      b++;
    end
    check_eq(tag, cmd_bus.cmd_valid, 1);
  endtask

  task automatic man_cmd(input logic rw, input logic [31:0] d);
    man_rw    = rw;
    man_data  = d;
    man_start = 1'b1;
    step(1);
    man_start = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = a[ADDR_W-1:0];
    tbl_wr_data = d;
    step(1);
    tbl_wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0, n1, w0, d0;
    cmd_bus.cmd_ready = 1'b0;

    // Reset state
    step(2);
    check_eq("rst_valid", cmd_bus.cmd_valid, 0);
    check_eq("rst_rw", cmd_bus.cmd_rw, 0);
    check_eq("rst_data", cmd_bus.cmd_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_idx", seq_idx, 0);
    check_eq("rst_wrap", seq_wrap, 0);
    check_eq("rst_drop", man_drop, 0);
    rstn_i = 1'b1;
    step(2);

    // Manual write, ready tied high
    cmd_bus.cmd_ready = 1'b1;
    sb_q.push_back({1'b0, 32'h0C120D34});
    c0 = cyc;
    man_cmd(1'b0, 32'h0C120D34);
    wait_empty("man_write", 20);
    step(3);
    check_eq("man_latency", rise_cyc, c0 + 3);
    check_eq("man_count", xcyc.size(), 1);
    check_eq("man_busy", busy, 0);

    // Handshake hold with ready low for 20 cycles
    cmd_bus.cmd_ready = 1'b0;
    sb_q.push_back({1'b1, 32'h04000500});
    man_cmd(1'b1, 32'h04000500);
    wait_valid("hold_rise", 20);
    step(20);
    check_eq("hold_still_valid", cmd_bus.cmd_valid, 1);
    cmd_bus.cmd_ready = 1'b1;
    wait_empty("hold_xfer", 10);
    step(3);
    check_eq("hold_count", xcyc.size(), 2);
    check_eq("hold_busy", busy, 0);

    // Sequence loop
    load(0, 32'h11);
    load(1, 32'h22);
    load(2, 32'h33);
    for (int i = 3; i < 8; i++) load(i, 32'hE0 + i);
    seq_last = 3'd2;
    dwell    = 5;
    n0 = xcyc.size();
    w0 = wrap_cnt;
    sb_q.push_back({1'b0, 32'h11});
    sb_q.push_back({1'b0, 32'h22});
    sb_q.push_back({1'b0, 32'h33});
    sb_q.push_back({1'b0, 32'h11});
    run_seq = 1'b1;
    wait_empty("seq_loop", 100);
    for (int i = 1; i < 4; i++) check_eq("seq_gap", xcyc[n0+i] - xcyc[n0+i-1], 8);
    check_eq("seq_wrap_cnt", wrap_cnt - w0, 1);

    // Manual insertion during the dwell after 22, plus a dropped second edge
    sb_q.push_back({1'b0, 32'h22});
    wait_empty("ins_22", 20);
    step(1);
    sb_q.push_back({1'b0, 32'hAA});
    sb_q.push_back({1'b0, 32'h33});
    d0 = drop_cnt;
    man_cmd(1'b0, 32'hAA);
    step(1);
    man_cmd(1'b1, 32'hBB);
    wait_empty("ins_order", 100);
    check_eq("ins_drop", drop_cnt - d0, 1);

    // Stop in SEQ_DWELL
    step(1);
    step(1);
    run_seq = 1'b0;
    n1 = xcyc.size();
    step(30);
    check_eq("stop_count", xcyc.size(), n1);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_idx", seq_idx, 2);

    // Restart with ready low, then drop run_seq while valid
    cmd_bus.cmd_ready = 1'b0;
    sb_q.push_back({1'b0, 32'h11});
    run_seq = 1'b1;
    wait_valid("restart_rise", 20);
    run_seq = 1'b0;
    step(5);
    check_eq("restart_valid", cmd_bus.cmd_valid, 1);
    check_eq("restart_data", cmd_bus.cmd_data, 32'h11);
    cmd_bus.cmd_ready = 1'b1;
    wait_empty("restart_xfer", 10);
    step(3);
    check_eq("restart_busy", busy, 0);

    // seq_last = 0, dwell = 0: entry 0 repeated, wrap every pass
    seq_last = 3'd0;
    dwell    = 0;
    n0 = xcyc.size();
    w0 = wrap_cnt;
    for (int i = 0; i < 3; i++) sb_q.push_back({1'b0, 32'h11});
    run_seq = 1'b1;
    wait_empty("last0", 50);
    run_seq = 1'b0;
    check_eq("last0_wrap", wrap_cnt - w0, 2);
    check_eq("last0_gap1", xcyc[n0+1] - xcyc[n0], 3);
    check_eq("last0_gap2", xcyc[n0+2] - xcyc[n0+1], 3);
    step(5);

    // Async reset mid-handshake
    seq_last = 3'd2;
    dwell    = 3;
    sb_q.push_back({1'b0, 32'h11});
    sb_q.push_back({1'b0, 32'h22});
    run_seq = 1'b1;
    wait_empty("arst_seq", 50);
    step(1);
    cmd_bus.cmd_ready = 1'b0;
    man_cmd(1'b0, 32'hCC);
    wait_valid("arst_rise", 30);
    check_eq("arst_pre_data", cmd_bus.cmd_data, 32'hCC);
    check_eq("arst_pre_idx", seq_idx, 2);
    @(negedge sys_clk);
    #2;
    rstn_i = 1'b0;
    #1;
    check_eq("arst_valid", cmd_bus.cmd_valid, 0);
    check_eq("arst_idx", seq_idx, 0);
    check_eq("arst_busy", busy, 0);
    run_seq = 1'b0;
    step(2);
    rstn_i = 1'b1;
    cmd_bus.cmd_ready = 1'b1;
    n1 = xcyc.size();
    step(10);
    check_eq("arst_no_pend", xcyc.size(), n1);
    check_eq("arst_idle", busy, 0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
